// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin, packet-locked arbiter that merges NUM_REQ
// AXI-Stream requesters onto one mesh ingress port. A grant is held from the
// first beat to the (possibly forced) last beat of a packet. Arbitration
// spends one IDLE cycle per packet.

// Per-requester slice: gates ready toward the requester and masks its
// valid/last/data so the top level can OR-combine all lanes.
module noc_inject_lane #(
    parameter int TDATAW = 32
) (
    input  logic              sel,
    input  logic              m_tready,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    input  logic [TDATAW-1:0] s_tdata,
    output logic              s_tready,
    output logic              vld,
    output logic              lst,
    output logic [TDATAW-1:0] data
);
    // sel is only ever set for the locked requester, so this is the mux leg
    assign s_tready = sel & m_tready;
    assign vld      = sel & s_tvalid;
    assign lst      = sel & s_tlast;
    assign data     = sel ? s_tdata : '0;
endmodule

module noc_inject_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int TDATAW    = 32,
    parameter int TDESTW    = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        S_TVALID,
    output logic [NUM_REQ-1:0]        S_TREADY,
    input  logic [NUM_REQ*TDATAW-1:0] S_TDATA,
    input  logic [NUM_REQ-1:0]        S_TLAST,
    input  logic [NUM_REQ*TDESTW-1:0] S_TDEST,
    output logic                      M_TVALID,
    input  logic                      M_TREADY,
    output logic [TDATAW-1:0]         M_TDATA,
    output logic                      M_TLAST,
    output logic [TDESTW-1:0]         M_TDEST,
    output logic [NUM_REQ-1:0]        GRANT_O,
    output logic                      ERR_O
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                           state;
    logic [GW-1:0]                    g_idx;
    logic [GW-1:0]                    last_grant;
    logic [GW-1:0]                    win;
    logic [CW-1:0]                    beat_cnt;
    logic [TDESTW-1:0]                dest_q;
    logic [NUM_REQ-1:0][TDATAW-1:0]   s_data;
    logic [NUM_REQ-1:0][TDESTW-1:0]   s_dest;
    logic [NUM_REQ-1:0]               lane_vld;
    logic [NUM_REQ-1:0]               lane_lst;
    logic [NUM_REQ-1:0][TDATAW-1:0]   lane_data;
    logic                             raw_last;
    logic                             cnt_max;
    logic                             hs;

    assign s_data = S_TDATA;
    assign s_dest = S_TDEST;

    // GRANT_O is all-zero outside LOCKED, so it doubles as the lane select
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        noc_inject_lane #(.TDATAW(TDATAW)) u_lane (
            .sel      (GRANT_O[i]),
            .m_tready (M_TREADY),
            .s_tvalid (S_TVALID[i]),
            .s_tlast  (S_TLAST[i]),
            .s_tdata  (s_data[i]),
            .s_tready (S_TREADY[i]),
            .vld      (lane_vld[i]),
            .lst      (lane_lst[i]),
            .data     (lane_data[i])
        );
    end

    // OR-combine the masked lanes into the router-facing data bus
    always_comb begin
        M_TDATA = '0;
        for (int i = 0; i < NUM_REQ; i++)
            M_TDATA = M_TDATA | lane_data[i];
    end

    assign raw_last = |lane_lst;
    assign cnt_max  = (beat_cnt == CW'(MAX_BEATS - 1));
    assign M_TVALID = |lane_vld;
    assign M_TLAST  = raw_last | ((state == LOCKED) & cnt_max);
    assign M_TDEST  = dest_q;
    assign hs       = M_TVALID & M_TREADY;

    // Round-robin search starting just after the previous winner
    always_comb begin
        logic          found;
        int            idx;
        logic [GW-1:0] idx_g;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_g = GW'(idx);
            if (!found && S_TVALID[idx_g]) begin
                found = 1'b1;
                win   = idx_g;
            end
        end
    end

    // Packet FSM: lock onto the winner, count beats, release on (forced) last
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            GRANT_O    <= '0;
            g_idx      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            dest_q     <= '0;
            ERR_O      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|S_TVALID) begin
                        state    <= LOCKED;
                        GRANT_O  <= NUM_REQ'(1) << win;
                        g_idx    <= win;
                        dest_q   <= s_dest[win];
                        beat_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (M_TLAST) begin
                            state      <= IDLE;
                            GRANT_O    <= '0;
                            last_grant <= g_idx;
                            // truncated packet: the requester never flagged last
                            if (cnt_max && !raw_last) ERR_O <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter (NUM_REQ=2, TDATAW=32, TDESTW=4,
// MAX_BEATS=16). Each task drives one scenario and checks inline against
// hand-computed values.
module tb_noc_inject_arbiter;
    logic        CLK;
    logic        RST;
    logic [1:0]  S_TVALID;
    logic [1:0]  S_TREADY;
    logic [63:0] S_TDATA;
    logic [1:0]  S_TLAST;
    logic [7:0]  S_TDEST;
    logic        M_TVALID;
    logic        M_TREADY;
    logic [31:0] M_TDATA;
    logic        M_TLAST;
    logic [3:0]  M_TDEST;
    logic [1:0]  GRANT_O;
    logic        ERR_O;

    int n_checks = 0;
    int n_fail   = 0;

    noc_inject_arbiter #(.NUM_REQ(2), .TDATAW(32), .TDESTW(4), .MAX_BEATS(16)) dut (
        .CLK(CLK), .RST(RST),
        .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
        .S_TLAST(S_TLAST), .S_TDEST(S_TDEST),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
        .M_TLAST(M_TLAST), .M_TDEST(M_TDEST),
        .GRANT_O(GRANT_O), .ERR_O(ERR_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [31:0] d, input logic [3:0] dst);
        S_TVALID[i]          = v;
        S_TLAST[i]           = l;
        S_TDATA[i*32 +: 32]  = d;
        S_TDEST[i*4 +: 4]    = dst;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TDEST = '0;
        M_TREADY = 1'b1;
        cyc(); cyc();
        RST = 1'b0;
        #1;
    endtask

    // Outputs while reset is held, even with requesters pending
    task automatic test_reset();
        RST = 1'b1;
        S_TVALID = 2'b11; S_TLAST = '0; S_TDATA = '0; S_TDEST = 8'h55;
        M_TREADY = 1'b1;
        cyc(); cyc();
        n_checks++; if (GRANT_O !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", GRANT_O); end
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got=%b exp=0", M_TVALID); end
        n_checks++; if (S_TREADY !== 2'b00) begin n_fail++; $display("FAIL reset_sready got=%b exp=00", S_TREADY); end
        n_checks++; if (ERR_O !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", ERR_O); end
        n_checks++; if (M_TDEST !== 4'h0) begin n_fail++; $display("FAIL reset_tdest got=%h exp=0", M_TDEST); end
        RST = 1'b0;
        S_TVALID = '0;
        #1;
    endtask

    // req0, 3 beats D0..D2, tdest 3, ready always high
    task automatic test_single();
        logic [31:0] d[3] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002};
        do_reset();
        set_req(0, 1'b1, 1'b0, d[0], 4'h3);
        #1;
        n_checks++; if (GRANT_O !== 2'b00 || M_TVALID !== 1'b0) begin n_fail++; $display("FAIL single_idle grant=%b mvalid=%b exp=00/0", GRANT_O, M_TVALID); end
        cyc();
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, (k == 2), d[k], 4'h3);
            #1;
            n_checks++; if (GRANT_O !== 2'b01) begin n_fail++; $display("FAIL single_grant beat=%0d got=%b exp=01", k, GRANT_O); end
            n_checks++; if (M_TVALID !== 1'b1 || M_TDATA !== d[k]) begin n_fail++; $display("FAIL single_data beat=%0d vld=%b got=%h exp=%h", k, M_TVALID, M_TDATA, d[k]); end
            n_checks++; if (M_TLAST !== (k == 2) || M_TDEST !== 4'h3) begin n_fail++; $display("FAIL single_last_dest beat=%0d last=%b dest=%h exp=%b/3", k, M_TLAST, M_TDEST, (k == 2)); end
            n_checks++; if (S_TREADY !== 2'b01) begin n_fail++; $display("FAIL single_sready beat=%0d got=%b exp=01", k, S_TREADY); end
            cyc();
        end
        set_req(0, 1'b0, 1'b0, '0, 4'h0);
        #1;
        n_checks++; if (GRANT_O !== 2'b00 || M_TVALID !== 1'b0) begin n_fail++; $display("FAIL single_release grant=%b mvalid=%b exp=00/0", GRANT_O, M_TVALID); end
    endtask

    // Both requesters stream 2-beat packets back to back for 12 cycles
    task automatic test_contention();
        logic [1:0]  eg[12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        logic [31:0] ed[12] = '{32'h0, 32'h000, 32'h001, 32'h0, 32'h100, 32'h101,
                                32'h0, 32'h002, 32'h003, 32'h0, 32'h102, 32'h103};
        int cnt0 = 0;
        int cnt1 = 0;
        int beats = 0;
        logic [1:0] rdy;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            set_req(0, 1'b1, cnt0[0], 32'(cnt0), 4'h1);
            set_req(1, 1'b1, cnt1[0], 32'h100 + 32'(cnt1), 4'h2);
            #1;
            n_checks++; if (GRANT_O !== eg[c]) begin n_fail++; $display("FAIL cont_grant cyc=%0d got=%b exp=%b", c, GRANT_O, eg[c]); end
            if (eg[c] != 2'b00) begin
                n_checks++; if (M_TVALID !== 1'b1 || M_TDATA !== ed[c] || M_TLAST !== ed[c][0]) begin
                    n_fail++; $display("FAIL cont_beat cyc=%0d vld=%b data=%h last=%b exp=1/%h/%b", c, M_TVALID, M_TDATA, M_TLAST, ed[c], ed[c][0]);
                end
            end
            if (M_TVALID && M_TREADY) beats++;
            rdy = S_TREADY;
            cyc();
            if (rdy[0]) cnt0++;
            if (rdy[1]) cnt1++;
        end
        n_checks++; if (beats != 8) begin n_fail++; $display("FAIL cont_beats got=%0d exp=8", beats); end
        S_TVALID = '0;
        #1;
    endtask

    // M_TREADY toggles 1,0,1,0.. during a 4-beat req0 packet
    task automatic test_backpressure();
        int k = 0;
        logic r;
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h10, 4'h5);
        cyc();
        for (int c = 0; c < 7; c++) begin
            r = (c % 2 == 0);
            M_TREADY = r;
            set_req(0, 1'b1, (k == 3), 32'h10 + 32'(k), 4'h5);
            #1;
            n_checks++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'h10 + 32'(k)) begin n_fail++; $display("FAIL bp_data cyc=%0d vld=%b got=%h exp=%h", c, M_TVALID, M_TDATA, 32'h10 + 32'(k)); end
            n_checks++; if (S_TREADY !== {1'b0, r}) begin n_fail++; $display("FAIL bp_sready cyc=%0d got=%b exp=%b", c, S_TREADY, {1'b0, r}); end
            cyc();
            if (r) k++;
        end
        set_req(0, 1'b0, 1'b0, '0, 4'h0);
        M_TREADY = 1'b1;
        #1;
        n_checks++; if (k != 4 || GRANT_O !== 2'b00) begin n_fail++; $display("FAIL bp_done beats=%0d grant=%b exp=4/00", k, GRANT_O); end
    endtask

    // req1 sends 20 beats with TLAST never set; beat 16 is forced last
    task automatic test_overlength();
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'h200, 4'h9);
        cyc();
        for (int k = 0; k < 16; k++) begin
            set_req(1, 1'b1, 1'b0, 32'h200 + 32'(k), 4'h9);
            #1;
            n_checks++; if (GRANT_O !== 2'b10 || M_TDATA !== 32'h200 + 32'(k)) begin n_fail++; $display("FAIL ovl_beat k=%0d grant=%b data=%h", k, GRANT_O, M_TDATA); end
            n_checks++; if (M_TLAST !== (k == 15) || ERR_O !== 1'b0) begin n_fail++; $display("FAIL ovl_last k=%0d last=%b err=%b exp=%b/0", k, M_TLAST, ERR_O, (k == 15)); end
            cyc();
        end
        n_checks++; if (ERR_O !== 1'b1 || GRANT_O !== 2'b00) begin n_fail++; $display("FAIL ovl_release err=%b grant=%b exp=1/00", ERR_O, GRANT_O); end
        cyc();
        for (int k = 16; k < 20; k++) begin
            set_req(1, 1'b1, 1'b0, 32'h200 + 32'(k), 4'h9);
            #1;
            n_checks++; if (GRANT_O !== 2'b10 || M_TLAST !== 1'b0 || M_TDATA !== 32'h200 + 32'(k)) begin n_fail++; $display("FAIL ovl_tail k=%0d grant=%b last=%b data=%h", k, GRANT_O, M_TLAST, M_TDATA); end
            cyc();
        end
        set_req(1, 1'b0, 1'b0, '0, 4'h9);
        #1;
        n_checks++; if (M_TVALID !== 1'b0 || GRANT_O !== 2'b10 || ERR_O !== 1'b1) begin n_fail++; $display("FAIL ovl_stall vld=%b grant=%b err=%b exp=0/10/1", M_TVALID, GRANT_O, ERR_O); end
    endtask

    // Valid drops right after arbitration: grant is kept, output idles
    task automatic test_valid_drop();
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h55, 4'h4);
        cyc();
        set_req(0, 1'b0, 1'b1, 32'h55, 4'h4);
        #1;
        n_checks++; if (M_TVALID !== 1'b0 || GRANT_O !== 2'b01 || S_TREADY !== 2'b01) begin n_fail++; $display("FAIL drop_hold vld=%b grant=%b srdy=%b exp=0/01/01", M_TVALID, GRANT_O, S_TREADY); end
        cyc(); cyc();
        n_checks++; if (GRANT_O !== 2'b01) begin n_fail++; $display("FAIL drop_keep grant=%b exp=01", GRANT_O); end
        set_req(0, 1'b1, 1'b1, 32'h55, 4'h4);
        #1;
        n_checks++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'h55 || M_TLAST !== 1'b1) begin n_fail++; $display("FAIL drop_resume vld=%b data=%h last=%b exp=1/55/1", M_TVALID, M_TDATA, M_TLAST); end
        cyc();
        set_req(0, 1'b0, 1'b0, '0, 4'h0);
        #1;
        n_checks++; if (GRANT_O !== 2'b00) begin n_fail++; $display("FAIL drop_release grant=%b exp=00", GRANT_O); end
    endtask

    // Single-beat req1 packet takes 2 cycles; then round robin favours req0
    task automatic test_single_beat();
        do_reset();
        set_req(1, 1'b1, 1'b1, 32'hBEEF, 4'h6);
        #1;
        n_checks++; if (GRANT_O !== 2'b00) begin n_fail++; $display("FAIL sb_idle grant=%b exp=00", GRANT_O); end
        cyc();
        n_checks++; if (GRANT_O !== 2'b10 || M_TVALID !== 1'b1 || M_TLAST !== 1'b1 || M_TDATA !== 32'hBEEF) begin
            n_fail++; $display("FAIL sb_beat grant=%b vld=%b last=%b data=%h exp=10/1/1/beef", GRANT_O, M_TVALID, M_TLAST, M_TDATA);
        end
        set_req(0, 1'b1, 1'b1, 32'hA0, 4'h1);
        set_req(1, 1'b1, 1'b1, 32'hA1, 4'h2);
        cyc();
        n_checks++; if (GRANT_O !== 2'b00) begin n_fail++; $display("FAIL sb_two_cycles grant=%b exp=00", GRANT_O); end
        cyc();
        n_checks++; if (GRANT_O !== 2'b01 || M_TDATA !== 32'hA0) begin n_fail++; $display("FAIL sb_rr grant=%b data=%h exp=01/a0", GRANT_O, M_TDATA); end
        S_TVALID = '0;
        cyc();
    endtask

    // tdest changes after beat 0 must not reach M_TDEST; leaves last_grant=0
    task automatic test_tdest_latch();
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h70, 4'h2);
        cyc();
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, (k == 2), 32'h70 + 32'(k), (k == 0) ? 4'h2 : 4'h7);
            #1;
            n_checks++; if (M_TDEST !== 4'h2) begin n_fail++; $display("FAIL tdest beat=%0d got=%h exp=2", k, M_TDEST); end
            cyc();
        end
        set_req(0, 1'b0, 1'b0, '0, 4'h0);
        #1;
    endtask

    // Reset during beat 2 of 5 aborts; afterwards req0 wins first again
    task automatic test_reset_mid();
        M_TREADY = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h300, 4'hA);
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_req(0, 1'b1, 1'b0, 32'h300 + 32'(k), 4'hA);
            cyc();
        end
        set_req(0, 1'b1, 1'b0, 32'h302, 4'hA);
        #1;
        n_checks++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'h302) begin n_fail++; $display("FAIL rm_pre vld=%b data=%h exp=1/302", M_TVALID, M_TDATA); end
        #1 RST = 1'b1;
        #1;
        n_checks++; if (M_TVALID !== 1'b0 || GRANT_O !== 2'b00 || ERR_O !== 1'b0 || S_TREADY !== 2'b00) begin
            n_fail++; $display("FAIL rm_abort vld=%b grant=%b err=%b srdy=%b exp=0/00/0/00", M_TVALID, GRANT_O, ERR_O, S_TREADY);
        end
        cyc();
        RST = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h400, 4'h1);
        set_req(1, 1'b1, 1'b0, 32'h401, 4'h2);
        #1;
        n_checks++; if (GRANT_O !== 2'b00) begin n_fail++; $display("FAIL rm_idle grant=%b exp=00", GRANT_O); end
        cyc();
        n_checks++; if (GRANT_O !== 2'b01 || M_TDATA !== 32'h400) begin n_fail++; $display("FAIL rm_restart grant=%b data=%h exp=01/400", GRANT_O, M_TDATA); end
        S_TVALID = '0;
        cyc();
    endtask

    initial begin
        RST = 1'b1;
        S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TDEST = '0;
        M_TREADY = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_overlength();
        test_valid_drop();
        test_single_beat();
        test_tdest_latch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of AXI-Stream requesters sharing one mesh ingress port.
REQ-002 Parameter TDATAW, default 32: tdata width.
REQ-003 Parameter TDESTW, default 4: tdest width.
REQ-004 Parameter MAX_BEATS, default 16: longest legal packet, in beats.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port CLK, in, 1: the single clock; all state changes on its rising edge.
REQ-007 Port RST, in, 1: asynchronous reset, active high.
REQ-008 Port S_TVALID, in, NUM_REQ: per-requester valid.
REQ-009 Port S_TREADY, out, NUM_REQ: per-requester ready.
REQ-010 Port S_TDATA, in, NUM_REQ*TDATAW: requester i occupies bits [i*TDATAW +: TDATAW].
REQ-011 Port S_TLAST, in, NUM_REQ: per-requester last-beat flag.
REQ-012 Port S_TDEST, in, NUM_REQ*TDESTW: per-requester destination.
REQ-013 Port M_TVALID, out, 1: valid toward the router.
REQ-014 Port M_TREADY, in, 1: ready from the router.
REQ-015 Port M_TDATA, out, TDATAW: data toward the router.
REQ-016 Port M_TLAST, out, 1: last-beat flag toward the router.
REQ-017 Port M_TDEST, out, TDESTW: destination toward the router.
REQ-018 Port GRANT_O, out, NUM_REQ: one-hot current grant; all zero in IDLE.
REQ-019 Port ERR_O, out, 1: sticky error flag for an over-length packet.

Function
REQ-020 The FSM SHALL have two states, IDLE and LOCKED.
REQ-021 IDLE behaviour:
- S_TREADY, M_TVALID and GRANT_O are all 0.
- When any S_TVALID is 1, the block registers the round-robin winner into GRANT_O and moves to LOCKED on the next edge.
REQ-022 Round-robin priority:
- Search starts at index last_grant+1 and wraps modulo NUM_REQ.
- The first requester with S_TVALID=1 wins.
REQ-023 The winner's S_TDEST SHALL be latched on the IDLE->LOCKED edge.
- M_TDEST drives the latched value for the whole packet.
- Later beats' S_TDEST are ignored.
REQ-024 LOCKED datapath, combinational passthrough from granted requester g:
- M_TVALID = S_TVALID[g]
- M_TDATA = S_TDATA[g]
- S_TREADY[g] = M_TREADY
- S_TREADY of every other requester = 0.
REQ-025 M_TLAST in LOCKED SHALL equal S_TLAST[g] OR (beat_cnt == MAX_BEATS-1).
REQ-026 Beat counter:
- beat_cnt is cleared on entry to LOCKED.
- It increments on each M_TVALID & M_TREADY handshake.
- Its width is clog2(MAX_BEATS)+1 bits.
REQ-027 On a handshake with M_TLAST=1, the block SHALL:
- return to IDLE on the next edge;
- store last_grant=g;
- clear GRANT_O.
REQ-028 When the forced-last condition fires (count reaches MAX_BEATS-1 and S_TLAST[g]=0 on the handshake), the block SHALL set ERR_O=1 and hold it until reset.
REQ-029 Grant lifetime:
- The grant is never revoked mid-packet.
- S_TVALID deasserting in LOCKED stalls the output (M_TVALID=0) without releasing the grant.
REQ-030 Arbitration costs one IDLE cycle per packet.
- Peak throughput is L/(L+1) beats per cycle for L-beat packets.
- Handshake-to-output latency is 0 cycles.
REQ-031 A requester deasserting S_TVALID between arbitration and LOCKED SHALL keep the grant, with no output activity until it reasserts.
REQ-032 A single-beat packet (S_TLAST=1 on beat 0) SHALL occupy exactly 2 cycles with M_TREADY=1: one IDLE cycle and one LOCKED cycle.

Reset
REQ-033 While RST=1, asynchronously:
- state=IDLE;
- GRANT_O=0, M_TVALID=0, S_TREADY=0, ERR_O=0, beat_cnt=0, M_TDEST latch=0;
- last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-034 Reset asserted mid-packet SHALL abort the packet.
- The router sees no further beats.
- After reset deasserts, arbitration restarts from requester 0.
REQ-035 Outputs SHALL be stable and defined from the first CLK edge after RST deasserts.

Verification
REQ-036 Single requester: req0 sends a 3-beat packet (D0..D2, tdest=4'h3) with M_TREADY=1.
- M_TVALID high for cycles 1-3; data D0,D1,D2; M_TDEST=3; M_TLAST on D2.
- GRANT_O=01 during cycles 1-3, then 00.
REQ-037 Contention: req0 and req1 both hold continuous 2-beat packets.
- Grants alternate 01,10,01,10.
- No beat interleaving within a packet.
- 4 packets in 12 cycles.
REQ-038 Backpressure: M_TREADY toggles 1,0,1,0 during a 4-beat packet.
- Each beat is presented until accepted.
- S_TREADY[g] mirrors M_TREADY.
- No beat is lost or duplicated.
REQ-039 Overlength packet: MAX_BEATS=16, req1 sends 20 beats with TLAST never set.
- Beat 16 carries M_TLAST=1, ERR_O=1, grant released.
- The remaining 4 beats arbitrate as a new packet.
REQ-040 tdest change mid-packet: req0 sets tdest=2 on beat 0 and tdest=7 on beats 1-2 → M_TDEST=2 for all 3 beats.
REQ-041 Reset mid-packet: RST pulses during beat 2 of 5.
- M_TVALID=0 immediately.
- GRANT_O=00 and ERR_O=0.
- After release with both valid, requester 0 wins first.
